fetch_unit: RTL and testbench

Instruction fetch front end that drives the instruction word and its PC into the control unit and datapath. It consumes the redirect decision (branch taken / jump) and target produced downstream.
- Owns the fetch PC.
- Issues one-outstanding requests to instruction memory over a req/ack handshake.
- Holds the returned word in a one-entry buffer until consumed.
- Handles redirects that arrive mid-request by squashing stale data.

---
 rtl/fetch_unit.sv | 136 +++++++++++++
 tb/tb_fetch_unit.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch front end.
// Owns the fetch PC, issues one outstanding request at a time to instruction
// memory over a req/ack handshake, holds the returned word in a one-entry
// buffer until decode consumes it, and squashes stale returns when a
// redirect arrives while a request is in flight.
//
// Ports:
//   clk              clock, all state updates on the rising edge
//   rst              asynchronous active-low reset
//   imem_req         fetch request to instruction memory
//   imem_addr        word-aligned fetch address
//   imem_ack         memory returns data this cycle (only honoured in REQ)
//   imem_rdata       instruction word, valid with imem_ack
//   instr            buffered instruction to decode
//   instr_valid      instr/pc hold a live instruction
//   instr_ready      decode consumes instr this edge when instr_valid=1
//   pc               address of instr
//   redirect         branch-taken or jump resolved this cycle
//   redirect_target  new fetch address, bits[1:0] forced to 0
//   squash_count     saturating count of discarded fetched words
module fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'hBFC00000,
  parameter int unsigned CNT_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  output logic                 imem_req,
  output logic [31:0]          imem_addr,
  input  logic                 imem_ack,
  input  logic [31:0]          imem_rdata,
  output logic [31:0]          instr,
  output logic                 instr_valid,
  input  logic                 instr_ready,
  output logic [31:0]          pc,
  input  logic                 redirect,
  input  logic [31:0]          redirect_target,
  output logic [CNT_WIDTH-1:0] squash_count
);

  localparam logic [31:0] NOP = 32'h00000013;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    HOLD
  } state_t;

  state_t               r_state;
  logic                 r_req;
  logic [31:0]          r_fetch_pc;
  logic [31:0]          r_instr;
  logic [31:0]          r_pc;
  logic                 r_instr_valid;
  logic                 r_pend;
  logic [31:0]          r_pend_pc;
  logic [CNT_WIDTH-1:0] r_squash;

  logic [31:0]          w_target;
  logic [CNT_WIDTH-1:0] w_squash_inc;

  // Masking (rather than slicing) keeps every target bit in use.
  assign w_target     = redirect_target & ~32'h3;
  assign w_squash_inc = (r_squash == '1) ? r_squash : r_squash + 1'b1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state       <= IDLE;
      r_req         <= 1'b0;
      r_fetch_pc    <= RESET_PC;
      r_instr       <= NOP;
      r_pc          <= RESET_PC;
      r_instr_valid <= 1'b0;
      r_pend        <= 1'b0;
      r_pend_pc     <= RESET_PC;
      r_squash      <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (redirect) r_fetch_pc <= w_target;
          r_state <= REQ;
          r_req   <= 1'b1;
        end

        REQ: begin
          if (imem_ack) begin
            if (redirect || r_pend) begin
              // Stale return: drop it and re-issue at the newest target.
              // A same-edge redirect wins over the remembered one.
              r_squash   <= w_squash_inc;
              r_fetch_pc <= redirect ? w_target : r_pend_pc;
              r_pend     <= 1'b0;
            end else begin
              r_instr       <= imem_rdata;
              r_pc          <= r_fetch_pc;
              r_instr_valid <= 1'b1;
              r_fetch_pc    <= r_fetch_pc + 32'd4;
              r_state       <= HOLD;
              r_req         <= 1'b0;
            end
          end else if (redirect) begin
            // Address must stay put until ack; remember where to go next.
            r_pend    <= 1'b1;
            r_pend_pc <= w_target;
          end
        end

        HOLD: begin
          if (redirect) begin
            if (!instr_ready) r_squash <= w_squash_inc;
            r_instr_valid <= 1'b0;
            r_fetch_pc    <= w_target;
            r_state       <= REQ;
            r_req         <= 1'b1;
          end else if (instr_ready) begin
            r_instr_valid <= 1'b0;
            r_state       <= REQ;
            r_req         <= 1'b1;
          end
        end

        default: begin
          r_state <= IDLE;
          r_req   <= 1'b0;
        end
      endcase
    end
  end

  assign imem_req     = r_req;
  assign imem_addr    = r_fetch_pc;
  assign instr        = r_instr;
  assign instr_valid  = r_instr_valid;
  assign pc           = r_pc;
  assign squash_count = r_squash;

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] pc;
  logic        redirect;
  logic [31:0] redirect_target;
  logic [7:0]  squash_count;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  fetch_unit #(
    .RESET_PC (32'hBFC00000),
    .CNT_WIDTH(8)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_ack       (imem_ack),
    .imem_rdata     (imem_rdata),
    .instr          (instr),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .pc             (pc),
    .redirect       (redirect),
    .redirect_target(redirect_target),
    .squash_count   (squash_count)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_req(input string tag, input logic [31:0] addr);
    check_eq({tag, ".req"},  {31'd0, imem_req}, 32'd1);
    check_eq({tag, ".addr"}, imem_addr, addr);
  endtask

  task automatic expect_hold(input string tag, input logic [31:0] data, input logic [31:0] a);
    check_eq({tag, ".valid"}, {31'd0, instr_valid}, 32'd1);
    check_eq({tag, ".instr"}, instr, data);
    check_eq({tag, ".pc"},    pc, a);
    check_eq({tag, ".req"},   {31'd0, imem_req}, 32'd0);
  endtask

  task automatic expect_sq(input string tag, input int unsigned n);
    check_eq(tag, {24'd0, squash_count}, n);
  endtask

  task automatic do_ack(input logic [31:0] data);
    imem_ack   = 1'b1;
    imem_rdata = data;
    tick();
    imem_ack   = 1'b0;
    imem_rdata = 32'h0;
  endtask

  task automatic expect_reset_vals(input string tag);
    check_eq({tag, ".req"},   {31'd0, imem_req}, 32'd0);
    check_eq({tag, ".addr"},  imem_addr, 32'hBFC00000);
    check_eq({tag, ".instr"}, instr, 32'h00000013);
    check_eq({tag, ".valid"}, {31'd0, instr_valid}, 32'd0);
    check_eq({tag, ".pc"},    pc, 32'hBFC00000);
    expect_sq({tag, ".sq"}, 0);
  endtask

  initial begin
    rst = 1'b0; imem_ack = 1'b0; imem_rdata = '0; instr_ready = 1'b1;
    redirect = 1'b0; redirect_target = '0;
    tick(); tick();
    expect_reset_vals("rst");

    // Straight-line fetch with decode always ready.
    rst = 1'b1;
    check_eq("idle.req", {31'd0, imem_req}, 32'd0);
    tick();
    expect_req("f0", 32'hBFC00000);
    do_ack(32'h11111111);
    expect_hold("h0", 32'h11111111, 32'hBFC00000);
    tick();
    expect_req("f1", 32'hBFC00004);
    check_eq("f1.valid", {31'd0, instr_valid}, 32'd0);
    do_ack(32'h22222222);
    expect_hold("h1", 32'h22222222, 32'hBFC00004);
    tick();
    expect_req("f2", 32'hBFC00008);
    do_ack(32'h33333333);
    instr_ready = 1'b0;
    expect_hold("h2", 32'h33333333, 32'hBFC00008);
    expect_sq("f.sq", 0);

    // Backpressure: word held, no new request.
    for (int i = 0; i < 5; i++) begin
      tick();
      expect_hold("bp", 32'h33333333, 32'hBFC00008);
    end
    instr_ready = 1'b1;
    tick();
    expect_req("bp.next", 32'hBFC0000C);

    // Redirect in HOLD while consumed: no squash.
    do_ack(32'h44444444);
    expect_hold("h3", 32'h44444444, 32'hBFC0000C);
    redirect = 1'b1; redirect_target = 32'hBFC00100;
    tick();
    redirect = 1'b0;
    expect_req("rdh", 32'hBFC00100);
    check_eq("rdh.valid", {31'd0, instr_valid}, 32'd0);
    expect_sq("rdh.sq", 0);

    // Redirect in HOLD while not consumed: squash, low target bits dropped.
    do_ack(32'h55555555);
    instr_ready = 1'b0;
    redirect = 1'b1; redirect_target = 32'hBFC00102;
    tick();
    redirect = 1'b0; instr_ready = 1'b1;
    expect_req("rdh2", 32'hBFC00100);
    check_eq("rdh2.valid", {31'd0, instr_valid}, 32'd0);
    expect_sq("rdh2.sq", 1);

    // Redirect during an outstanding request: address holds, return dropped.
    redirect = 1'b1; redirect_target = 32'h00000200;
    tick();
    redirect = 1'b0;
    expect_req("pend.a", 32'hBFC00100);
    tick();
    expect_req("pend.b", 32'hBFC00100);
    tick();
    do_ack(32'hDEADBEEF);
    check_eq("pend.valid", {31'd0, instr_valid}, 32'd0);
    expect_req("pend.next", 32'h00000200);
    expect_sq("pend.sq", 2);

    // Two redirects before ack: last one wins.
    redirect = 1'b1; redirect_target = 32'h00000280;
    tick();
    redirect_target = 32'h00000300;
    tick();
    redirect = 1'b0;
    expect_req("pend2.a", 32'h00000200);
    do_ack(32'hBAD0BAD0);
    check_eq("pend2.valid", {31'd0, instr_valid}, 32'd0);
    expect_req("pend2.next", 32'h00000300);
    expect_sq("pend2.sq", 3);

    // Redirect on the same edge as ack.
    redirect = 1'b1; redirect_target = 32'h00000400;
    do_ack(32'hBAD1BAD1);
    redirect = 1'b0;
    check_eq("same.valid", {31'd0, instr_valid}, 32'd0);
    expect_req("same.next", 32'h00000400);
    expect_sq("same.sq", 4);

    // PC wrap at the top of the address space.
    redirect = 1'b1; redirect_target = 32'hFFFFFFFC;
    tick();
    redirect = 1'b0;
    do_ack(32'hBAD2BAD2);
    expect_req("wrap.a", 32'hFFFFFFFC);
    expect_sq("wrap.sq", 5);
    do_ack(32'h66666666);
    expect_hold("wrap.h", 32'h66666666, 32'hFFFFFFFC);
    tick();
    expect_req("wrap.next", 32'h00000000);

    // Saturation: 300 back-to-back squashes from count 5.
    imem_ack = 1'b1; imem_rdata = 32'hBAD3BAD3;
    redirect = 1'b1; redirect_target = 32'h00000000;
    for (int i = 0; i < 300; i++) tick();
    imem_ack = 1'b0; redirect = 1'b0;
    expect_sq("sat", 255);
    expect_req("sat.req", 32'h00000000);

    // Ack while not requesting is ignored.
    do_ack(32'h77777777);
    instr_ready = 1'b0;
    expect_hold("h6", 32'h77777777, 32'h00000000);
    imem_ack = 1'b1; imem_rdata = 32'hBAD4BAD4;
    tick();
    imem_ack = 1'b0;
    expect_hold("noreq", 32'h77777777, 32'h00000000);
    expect_sq("noreq.sq", 255);

    // Asynchronous reset mid-request; late ack ignored.
    instr_ready = 1'b1;
    tick();
    expect_req("mid", 32'h00000004);
    rst = 1'b0;
    #1;
    expect_reset_vals("arst");
    imem_ack = 1'b1; imem_rdata = 32'hBAD5BAD5;
    tick();
    imem_ack = 1'b0;
    expect_reset_vals("arst2");
    rst = 1'b1;
    tick();
    expect_req("post", 32'hBFC00000);
    do_ack(32'h88888888);
    expect_hold("post.h", 32'h88888888, 32'hBFC00000);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #100000;
    n_errors++;
    $display("FAIL timeout: got running expected finished");
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
